// File: rtl/djpeg_pixel_packer_if.sv
// rtl/djpeg_pixel_packer_if.sv - packed-word output stream between pixel packer and frame-buffer writer
interface djpeg_pixel_packer_if #(
  parameter int ADDR_W = 24
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-3:0] out_addr;
  logic [3:0]        out_be;
  logic [31:0]       out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_be,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_be,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/djpeg_pixel_packer.sv
// rtl/djpeg_pixel_packer.sv - pixel format conversion, address generation, word packing and output FIFO
module djpeg_pixel_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [1:0]                    mode,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [15:0]                   stride,
  input  logic                          flush,
  input  logic                          in_en,
  input  logic [15:0]                   in_x,
  input  logic [15:0]                   in_y,
  input  logic [7:0]                    in_r,
  input  logic [7:0]                    in_g,
  input  logic [7:0]                    in_b,
  djpeg_pixel_packer_if.master          out_if,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Pixel formatting and byte-address generation (combinational, input side)
  // ---------------------------------------------------------------------------
  logic [2:0]        w_bpp;
  logic [3:0]        w_be_base;
  logic [31:0]       w_pix;
  logic [7:0]        w_gray;
  logic [15:0]       w_rgb565;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;

  // Formatted pixel is replicated across all lanes so that shifting the byte
  // enables to the address lane is enough to place it correctly.
  always_comb begin
    w_gray   = 8'((16'(in_r) * 16'd77 + 16'(in_g) * 16'd150 + 16'(in_b) * 16'd29) >> 8);
    w_rgb565 = {in_r[7:3], in_g[7:2], in_b[7:3]};
    w_bpp     = 3'd4;
    w_be_base = 4'hF;
    w_pix     = {8'h00, in_r, in_g, in_b};
    case (mode)
      2'd1: begin
        w_bpp     = 3'd2;
        w_be_base = 4'b0011;
        w_pix     = {w_rgb565, w_rgb565};
      end
      2'd2: begin
        w_bpp     = 3'd1;
        w_be_base = 4'b0001;
        w_pix     = {w_gray, w_gray, w_gray, w_gray};
      end
      default: begin
        w_bpp     = 3'd4;
        w_be_base = 4'hF;
        w_pix     = {8'h00, in_r, in_g, in_b};
      end
    endcase
    w_addr = base_addr
           + ADDR_W'(32'(in_y) * 32'(stride))
           + ADDR_W'(19'(in_x) * 19'(w_bpp));
    w_be   = w_be_base << w_addr[1:0];
  end

  // ---------------------------------------------------------------------------
  // Stage S1: registered word address, lane enables and lane data
  // ---------------------------------------------------------------------------
  logic              r_s1_valid;
  logic [ADDR_W-3:0] r_s1_wa;
  logic [3:0]        r_s1_be;
  logic [31:0]       r_s1_data;

  // Capture one pixel per in_en strobe; the decoder cannot be stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_wa    <= '0;
      r_s1_be    <= '0;
      r_s1_data  <= '0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
      r_s1_wa    <= '0;
      r_s1_be    <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= in_en;
      if (in_en) begin
        r_s1_wa   <= w_addr[ADDR_W-1:2];
        r_s1_be   <= w_be;
        r_s1_data <= w_pix;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packer: one partially filled word, empty when be == 0
  // ---------------------------------------------------------------------------
  logic [ADDR_W-3:0] r_pk_wa;
  logic [3:0]        r_pk_be;
  logic [31:0]       r_pk_data;
  logic              r_flush_pend;

  logic [ADDR_W-3:0] w_pk_wa_n;
  logic [3:0]        w_pk_be_n;
  logic [31:0]       w_pk_data_n;
  logic              w_flush_pend_n;
  logic              w_push;
  logic [31:0]       w_s1_mask;
  logic              w_conflict;

  // Decide merge / push / load for the packer; at most one push per cycle.
  always_comb begin
    w_pk_wa_n      = r_pk_wa;
    w_pk_be_n      = r_pk_be;
    w_pk_data_n    = r_pk_data;
    w_flush_pend_n = r_flush_pend | flush;
    w_push         = 1'b0;
    w_s1_mask      = {{8{r_s1_be[3]}}, {8{r_s1_be[2]}}, {8{r_s1_be[1]}}, {8{r_s1_be[0]}}};
    w_conflict     = (r_pk_be == 4'hF) || (r_s1_wa != r_pk_wa) || ((r_s1_be & r_pk_be) != 4'h0);
    if (r_s1_valid) begin
      if (r_pk_be == 4'h0 || w_conflict) begin
        w_push      = (r_pk_be != 4'h0);
        w_pk_wa_n   = r_s1_wa;
        w_pk_be_n   = r_s1_be;
        w_pk_data_n = r_s1_data;
      end else begin
        w_pk_be_n   = r_pk_be | r_s1_be;
        w_pk_data_n = (r_pk_data & ~w_s1_mask) | (r_s1_data & w_s1_mask);
      end
    end else begin
      if (r_pk_be == 4'hF || (r_flush_pend && r_pk_be != 4'h0)) begin
        w_push    = 1'b1;
        w_pk_be_n = 4'h0;
      end
      // A pending flush is consumed here; a new flush pulse re-arms it.
      if (r_flush_pend) begin
        w_flush_pend_n = flush;
      end
    end
  end

  // Packer and flush-pending state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pk_wa      <= '0;
      r_pk_be      <= '0;
      r_pk_data    <= '0;
      r_flush_pend <= 1'b0;
    end else if (clear) begin
      r_pk_wa      <= '0;
      r_pk_be      <= '0;
      r_pk_data    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_pk_wa      <= w_pk_wa_n;
      r_pk_be      <= w_pk_be_n;
      r_pk_data    <= w_pk_data_n;
      r_flush_pend <= w_flush_pend_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead output FIFO with AW+1-bit pointers
  // ---------------------------------------------------------------------------
  logic [ADDR_W-3:0] r_mem_addr [FIFO_DEPTH];
  logic [3:0]        r_mem_be   [FIFO_DEPTH];
  logic [31:0]       r_mem_data [FIFO_DEPTH];
  logic [AW:0]       r_wp;
  logic [AW:0]       r_rp;
  logic              r_ovf;

  logic [AW:0]       w_level;
  logic              w_nempty;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;
  logic              w_drop;

  // Occupancy, handshake and accept/drop decisions.
  always_comb begin
    w_level  = r_wp - r_rp;
    w_nempty = (w_level != '0);
    w_full   = (w_level == (AW+1)'(FIFO_DEPTH));
    w_pop    = w_nempty & out_if.out_ready;
    w_wr     = w_push & (~w_full | w_pop);
    w_drop   = w_push & w_full & ~w_pop;
  end

  // Storage array; not reset, outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (w_wr && !clear) begin
      r_mem_addr[r_wp[AW-1:0]] <= r_pk_wa;
      r_mem_be[r_wp[AW-1:0]]   <= r_pk_be;
      r_mem_data[r_wp[AW-1:0]] <= r_pk_data;
    end
  end

  // Pointer and sticky overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Head of FIFO presented combinationally; forced to zero while empty.
  always_comb begin
    out_if.out_valid = w_nempty;
    out_if.out_addr  = w_nempty ? r_mem_addr[r_rp[AW-1:0]] : '0;
    out_if.out_be    = w_nempty ? r_mem_be[r_rp[AW-1:0]]   : '0;
    out_if.out_data  = w_nempty ? r_mem_data[r_rp[AW-1:0]] : '0;
    level            = w_level;
    ovf              = r_ovf;
    busy             = r_s1_valid | (r_pk_be != 4'h0) | r_flush_pend | w_nempty;
  end

endmodule
